// File: rtl/gmrr_pkg.sv
// Shared widths for the gmrr predistortion path, plus the interpolation rounding helper.
package gmrr_pkg;

  localparam int AWIDTH = 9;
  localparam int FWIDTH = 7;
  localparam int DWIDTH = 32;
  localparam int TWIDTH = AWIDTH + FWIDTH;
  localparam int PWIDTH = DWIDTH + FWIDTH + 2;

  // Adds one half LSB of the fraction weight, then floors: half-up toward +inf.
  function automatic logic signed [DWIDTH-1:0] round_shift(input logic signed [PWIDTH-1:0] prod);
    logic signed [PWIDTH-1:0] half;
    half = '0;
    half[FWIDTH-1] = 1'b1;
    return DWIDTH'((prod + half) >>> FWIDTH);
  endfunction

endpackage

// File: rtl/interp_table_reader_if.sv
// Sample stream in/out plus the table RAM port A read signals of interp_table_reader.
interface interp_table_reader_if;
  import gmrr_pkg::*;

  logic [TWIDTH-1:0] i_tdata;
  logic              i_tlast;
  logic              i_tvalid;
  logic              i_tready;
  logic [DWIDTH-1:0] o_tdata;
  logic              o_tlast;
  logic              o_tvalid;
  logic              o_tready;
  logic              ram_en;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_do;
  logic [DWIDTH-1:0] ram_do_next;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready, ram_do, ram_do_next,
    output i_tready, o_tdata, o_tlast, o_tvalid, ram_en, ram_addr
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready, ram_do, ram_do_next,
    input  i_tready, o_tdata, o_tlast, o_tvalid, ram_en, ram_addr
  );

endinterface

// File: rtl/interp_lerp.sv
// Interpolation datapath: slope register, then fraction multiply, round and add into the output register.
module interp_lerp
  import gmrr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic [DWIDTH-1:0] d0_i,
  input  logic [DWIDTH-1:0] d1_i,
  input  logic [FWIDTH-1:0] frac_i,
  output logic [DWIDTH-1:0] y_o
);

  logic signed [DWIDTH:0]   diff_d;
  logic signed [DWIDTH:0]   diff_q;
  logic [DWIDTH-1:0]        d0_q;
  logic [FWIDTH-1:0]        frac_q;
  logic signed [FWIDTH:0]   frac_ext_s;
  logic signed [PWIDTH-1:0] prod_s;
  logic [DWIDTH-1:0]        y_d;
  logic [DWIDTH-1:0]        y_q;

  // Slope and weighted sum; the rounded term stays within [0, d1-d0] so y needs no saturation.
  always_comb begin
    diff_d     = $signed({d1_i[DWIDTH-1], d1_i}) - $signed({d0_i[DWIDTH-1], d0_i});
    frac_ext_s = $signed({1'b0, frac_q});
    prod_s     = PWIDTH'(diff_q) * PWIDTH'(frac_ext_s);
    y_d        = d0_q + round_shift(prod_s);
  end

  // S2 and S3 registers, frozen together with the rest of the pipeline on a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      diff_q <= '0;
      d0_q   <= '0;
      frac_q <= '0;
      y_q    <= '0;
    end else if (en_i) begin
      diff_q <= diff_d;
      d0_q   <= d0_i;
      frac_q <= frac_i;
      y_q    <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/interp_table_reader.sv
// Table read engine: issues one dual-entry read per sample and returns the interpolated entry 4 cycles later.
module interp_table_reader
  import gmrr_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  interp_table_reader_if.slave  bus
);

  logic              advance_s;
  logic              accept_s;
  logic              v0_q, v1_q, v2_q, v3_q;
  logic              last0_q, last1_q, last2_q, last3_q;
  logic [FWIDTH-1:0] frac0_q, frac1_q;
  logic [DWIDTH-1:0] d0_q, d1_q;

  // Stall control: every stage and the RAM read move only when the output slot can drain.
  always_comb begin
    advance_s    = ~v3_q | bus.o_tready;
    accept_s     = bus.i_tvalid & advance_s & ~reset;
    bus.i_tready = advance_s & ~reset;
    bus.ram_en   = accept_s;
    if (accept_s) begin
      bus.ram_addr = bus.i_tdata[TWIDTH-1:FWIDTH];
    end else begin
      bus.ram_addr = '0;
    end
  end

  // S0/S1 sideband and captured table entries; bubbles travel like samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
      frac0_q <= '0;
      frac1_q <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else if (advance_s) begin
      v0_q    <= accept_s;
      last0_q <= bus.i_tlast;
      frac0_q <= bus.i_tdata[FWIDTH-1:0];
      v1_q    <= v0_q;
      last1_q <= last0_q;
      frac1_q <= frac0_q;
      d0_q    <= bus.ram_do;
      d1_q    <= bus.ram_do_next;
      v2_q    <= v1_q;
      last2_q <= last1_q;
      v3_q    <= v2_q;
      last3_q <= last2_q;
    end
  end

  interp_lerp u_lerp (
    .clk    (clk),
    .reset  (reset),
    .en_i   (advance_s),
    .d0_i   (d0_q),
    .d1_i   (d1_q),
    .frac_i (frac1_q),
    .y_o    (bus.o_tdata)
  );

  assign bus.o_tvalid = v3_q;
  assign bus.o_tlast  = last3_q;

endmodule

// File: tb/tb_interp_table_reader.sv
// Bench for interp_table_reader: 512x32 table model with 1-cycle read latency and an arithmetic reference.
module tb_interp_table_reader;
  import gmrr_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic signed [31:0] mem [0:511];

  interp_table_reader_if bus();

  interp_table_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Port A of the table: registered read of an entry and its successor, last entry repeats.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      bus.ram_do      <= mem[bus.ram_addr];
      bus.ram_do_next <= (bus.ram_addr == 9'd511) ? mem[bus.ram_addr] : mem[bus.ram_addr + 9'd1];
    end
  end

  function automatic longint model_y(input int addr, input int frac);
    longint d0, d1, q, fl;
    d0 = mem[addr];
    d1 = (addr == 511) ? mem[511] : mem[addr + 1];
    q  = (d1 - d0) * frac + 64;
    fl = q / 128;
    if ((q % 128) != 0 && q < 0) fl = fl - 1;
    return d0 + fl;
  endfunction

  task automatic run_single(input int addr, input int frac, input longint exp_y, input string name);
    @(negedge clk);
    bus.o_tready = 1'b1;
    bus.i_tdata  = {addr[8:0], frac[6:0]};
    bus.i_tlast  = 1'b1;
    bus.i_tvalid = 1'b1;
    #1;
    total++;
    if (bus.i_tready !== 1'b1 || bus.ram_en !== 1'b1 || bus.ram_addr !== addr[8:0]) begin
      bad++;
      $display("FAIL %s_issue: i_tready=%b ram_en=%b ram_addr=%0d expected 1 1 %0d",
               name, bus.i_tready, bus.ram_en, bus.ram_addr, addr);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.i_tvalid = 1'b0;
      bus.i_tlast  = 1'b0;
      total++;
      if (c < 4) begin
        if (bus.o_tvalid !== 1'b0) begin
          bad++;
          $display("FAIL %s_early: o_tvalid=1 at cycle %0d, expected 0", name, c);
        end
      end else begin
        if (bus.o_tvalid !== 1'b1 || longint'($signed(bus.o_tdata)) !== exp_y || bus.o_tlast !== 1'b1) begin
          bad++;
          $display("FAIL %s: o_tvalid=%b o_tdata=%0d o_tlast=%b expected 1 %0d 1",
                   name, bus.o_tvalid, $signed(bus.o_tdata), bus.o_tlast, exp_y);
        end
      end
    end
    @(negedge clk);
    total++;
    if (bus.o_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL %s_once: o_tvalid=1 after handshake, expected 0", name);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
    bus.i_tdata  = '0;
    bus.o_tready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (bus.o_tvalid !== 1'b0 || bus.ram_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: o_tvalid=%b ram_en=%b expected 0 0", bus.o_tvalid, bus.ram_en);
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.o_tvalid !== 1'b0 || bus.o_tdata !== 32'd0 || bus.o_tlast !== 1'b0 ||
        bus.i_tready !== 1'b1 || bus.ram_addr !== 9'd0) begin
      bad++;
      $display("FAIL reset_state: o_tvalid=%b o_tdata=%0d o_tlast=%b i_tready=%b ram_addr=%0d expected 0 0 0 1 0",
               bus.o_tvalid, bus.o_tdata, bus.o_tlast, bus.i_tready, bus.ram_addr);
    end
  endtask

  task automatic test_basic();
    run_single(3, 0, 64'sd3000, "frac_zero");
    run_single(3, 64, 64'sd3500, "frac_half");
    run_single(3, 1, 64'sd3008, "frac_one");
  endtask

  task automatic test_negative_slope();
    mem[10] = 32'sd100;
    mem[11] = -32'sd100;
    run_single(10, 32, 64'sd50, "neg_quarter");
    run_single(10, 127, -64'sd98, "neg_max");
  endtask

  task automatic test_top_address();
    run_single(511, 127, 64'sd511000, "top_max");
    run_single(511, 0, 64'sd511000, "top_zero");
  endtask

  task automatic test_back_to_back();
    longint exp_q[$];
    bit     last_q[$];
    longint y;
    bit     l;
    int     sent = 0;
    int     recv = 0;
    int     cyc = 0;
    int     cur_addr;
    int     cur_frac;
    logic   prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic   prev_last = 1'b0;
    cur_addr = $urandom_range(0, 511);
    cur_frac = $urandom_range(0, 127);
    while (recv < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        total++;
        if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== prev_data || bus.o_tlast !== prev_last) begin
          bad++;
          $display("FAIL stall_hold: o_tvalid=%b o_tdata=%0d o_tlast=%b expected 1 %0d %b",
                   bus.o_tvalid, $signed(bus.o_tdata), bus.o_tlast, $signed(prev_data), prev_last);
        end
      end
      bus.o_tready = ($urandom_range(0, 99) >= 30);
      if (sent < 64) begin
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = {cur_addr[8:0], cur_frac[6:0]};
        bus.i_tlast  = (sent == 63);
      end else begin
        bus.i_tvalid = 1'b0;
        bus.i_tlast  = 1'b0;
      end
      #1;
      if (bus.o_tready) begin
        total++;
        if (bus.i_tready !== 1'b1) begin
          bad++;
          $display("FAIL throughput: i_tready=%b with o_tready=1, expected 1", bus.i_tready);
        end
      end
      if (bus.o_tvalid && bus.o_tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_output: o_tdata=%0d with no sample outstanding", $signed(bus.o_tdata));
        end else begin
          y = exp_q.pop_front();
          l = last_q.pop_front();
          if (longint'($signed(bus.o_tdata)) !== y || bus.o_tlast !== l) begin
            bad++;
            $display("FAIL stream[%0d]: o_tdata=%0d o_tlast=%b expected %0d %b",
                     recv, $signed(bus.o_tdata), bus.o_tlast, y, l);
          end
          recv++;
        end
      end
      if (bus.i_tvalid && bus.i_tready) begin
        exp_q.push_back(model_y(cur_addr, cur_frac));
        last_q.push_back(sent == 63);
        sent++;
        cur_addr = (sent == 20) ? 511 : $urandom_range(0, 511);
        cur_frac = $urandom_range(0, 127);
      end
      prev_stall = bus.o_tvalid && !bus.o_tready;
      prev_data  = bus.o_tdata;
      prev_last  = bus.o_tlast;
    end
    total++;
    if (recv != 64) begin
      bad++;
      $display("FAIL stream_count: received %0d samples, expected 64", recv);
    end
    bus.i_tvalid = 1'b0;
    bus.i_tlast  = 1'b0;
    bus.o_tready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      total++;
      if (bus.o_tvalid !== 1'b0) begin
        bad++;
        $display("FAIL stream_dup: o_tvalid=1 o_tdata=%0d after all samples, expected 0", $signed(bus.o_tdata));
      end
    end
  endtask

  task automatic test_reset_inflight();
    int waited = 0;
    bus.o_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = {9'(5 + i), 7'd0};
      bus.i_tlast  = 1'b0;
    end
    @(negedge clk);
    bus.i_tdata = {9'd8, 7'd0};
    while (bus.o_tvalid !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (bus.o_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL inflight_fill: o_tvalid=0 after %0d cycles, expected 1", waited);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus.o_tvalid !== 1'b0 || bus.ram_en !== 1'b0 || bus.o_tdata !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: o_tvalid=%b ram_en=%b o_tdata=%0d expected 0 0 0",
               bus.o_tvalid, bus.ram_en, bus.o_tdata);
    end
    bus.i_tvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      total++;
      if (bus.o_tvalid !== 1'b0) begin
        bad++;
        $display("FAIL stale_output: o_tvalid=1 o_tdata=%0d after reset, expected 0", $signed(bus.o_tdata));
      end
    end
    run_single(2, 0, 64'sd2000, "after_reset");
  endtask

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 32'(1000 * k);
    test_reset();
    test_basic();
    test_negative_slope();
    test_top_address();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
